llsc_link_monitor: RTL and testbench
====================================

Name: llsc_link_monitor

Overview:
- Consumer side of the LL/SC link protocol: ll establishes a link, this block resolves sc against it.
- Holds the link flag and the linked address (LLAddr).
- Snoops own-core stores and external bus writes to break the link.
- Answers sc requests from the MEM stage through a req/ack handshake with a pass/fail result.
- Sits beside the MEM/WB boundary; replaces the plain LL flag register in the multi-master configuration.

Parameters:
- ADDR_W, 32, address width of all address ports.
- GRAN_LSB, 2, low address bits ignored in compares (link granule = 2^GRAN_LSB bytes).
- TIMEOUT, 1023, cycles a link may live when the optional feature is enabled (1..65535).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  exception/eret; breaks the link.
- ll_valid  in  1  ll commits this cycle.
- ll_addr  in  ADDR_W  ll effective address.
- sc_req  in  1  sc request; level, held until sc_ack.
- sc_addr  in  ADDR_W  sc effective address; stable while sc_req is high.
- sc_ack  out  1  one-cycle pulse; result valid.
- sc_pass  out  1  qualified by sc_ack; 1 = store may proceed, rt<=1.
- st_valid  in  1  own ordinary store commits.
- st_addr  in  ADDR_W  own store address.
- snoop_valid  in  1  write by another master observed on bus.
- snoop_addr  in  ADDR_W  snooped write address.
- linked  out  1  current link flag.
- link_addr  out  ADDR_W  current LLAddr; 0 when never linked.

Behaviour:
- "match(a)" means a[ADDR_W-1:GRAN_LSB] == link_addr[ADDR_W-1:GRAN_LSB].
- Reset: linked=0, link_addr=0, sc_ack=0, sc_pass=0, FSM=S_IDLE; any pending request is dropped with no ack.
- Link flag: set by ll_valid (link_addr<=ll_addr). Cleared by:
  - flush;
  - st_valid with match(st_addr);
  - snoop_valid with match(snoop_addr);
  - sc acceptance, pass or fail.
- Per-cycle priority: rst > flush > sc acceptance > store/snoop clear > ll set.
- ll_valid together with a matching snoop_valid or st_valid on ll_addr: link not established; link_addr still updated.
- ll_valid with sc accepted in the same cycle: ll ignored, since a single-issue pipeline never produces this.
- sc FSM, S_IDLE and S_RESP:
  - S_IDLE with sc_req: accept. Result = linked & match(sc_addr), evaluated on pre-edge state, and forced 0 if flush, or a matching snoop_valid/st_valid, occurs in the same cycle. Register the result, clear linked, go to S_RESP.
  - S_RESP: sc_ack=1, sc_pass=result. Return to S_IDLE. sc_req seen during S_RESP is ignored; the requester drops it the cycle after ack.
  - Latency: ack exactly 1 cycle after acceptance; back-to-back sc throughput is 1 per 2 cycles.
  - flush while in S_RESP: ack still issued, sc_pass forced 0.
- sc_pass is 0 whenever sc_ack is 0.

Optional Feature:
- Macro LL_TIMEOUT_EN.
- Defined: a 16-bit counter reloads to 0 on each link set and increments while linked. When it reaches TIMEOUT, linked clears on the next edge; the counter also clears on rst/flush. This guarantees forward progress against livelocked spinners.
- Undefined: no counter exists; a link persists until an explicit clear event.

Test Plan:
- ll_valid, ll_addr=0x1000 → 3 idle cycles → sc_req, sc_addr=0x1002 → sc_ack one cycle later with sc_pass=1; linked=0 after.
- ll 0x1000 → snoop_valid, snoop_addr=0x1003 → sc 0x1000 → sc_pass=0. Repeat with snoop_addr=0x1004 → sc_pass=1.
- ll 0x2000 → flush pulse → sc 0x2000 → sc_pass=0. Separately: flush in the S_RESP cycle → sc_ack=1, sc_pass=0.
- ll 0x3000 → sc_req with sc_addr=0x3000 and a matching snoop_valid in the same cycle → sc_pass=0. sc_addr=0x4000 alone → sc_pass=0.
- sc_req pending, rst asserted in the acceptance cycle → no sc_ack; linked=0, link_addr=0.
- LL_TIMEOUT_EN, TIMEOUT=8: ll, then wait 8 cycles → linked drops → sc → sc_pass=0. sc issued at cycle 5 → sc_pass=1.

Source files
------------

// File: rtl/llsc_link_monitor_if.sv
// Signal bundle between the MEM/WB pipeline side (master) and the LL/SC link monitor (slave).
interface llsc_link_monitor_if #(
    parameter int ADDR_W = 32
);
    logic              flush;
    logic              ll_valid;
    logic [ADDR_W-1:0] ll_addr;
    logic              sc_req;
    logic [ADDR_W-1:0] sc_addr;
    logic              sc_ack;
    logic              sc_pass;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;
    logic              linked;
    logic [ADDR_W-1:0] link_addr;

    modport master (
        output flush, ll_valid, ll_addr, sc_req, sc_addr,
               st_valid, st_addr, snoop_valid, snoop_addr,
        input  sc_ack, sc_pass, linked, link_addr
    );

    modport slave (
        input  flush, ll_valid, ll_addr, sc_req, sc_addr,
               st_valid, st_addr, snoop_valid, snoop_addr,
        output sc_ack, sc_pass, linked, link_addr
    );
endinterface

// File: rtl/llsc_link_monitor.sv
// LL/SC link monitor: holds the link flag and LLAddr, breaks the link on stores/snoops/flush, answers sc.
// Optional link lifetime limit enabled by defining LL_TIMEOUT_EN.
module llsc_link_monitor #(
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2,
    parameter int TIMEOUT  = 1023
) (
    input logic                clk,
    input logic                rst,
    llsc_link_monitor_if.slave bus
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t            state;
    logic              linked_q;
    logic [ADDR_W-1:0] link_addr_q;
    logic              result_q;

    logic st_hit;
    logic snoop_hit;
    logic ll_blocked;
    logic accept;
    logic sc_ok;
    logic kill;
    logic ll_take;
    logic link_set;
    logic timeout_hit;

    function automatic logic same_granule(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB];
    endfunction

    always_comb begin
        st_hit     = bus.st_valid && same_granule(bus.st_addr, link_addr_q);
        snoop_hit  = bus.snoop_valid && same_granule(bus.snoop_addr, link_addr_q);
        ll_blocked = (bus.st_valid && same_granule(bus.st_addr, bus.ll_addr)) ||
                     (bus.snoop_valid && same_granule(bus.snoop_addr, bus.ll_addr));
        accept     = (state == S_IDLE) && bus.sc_req;
        sc_ok      = linked_q && same_granule(bus.sc_addr, link_addr_q) &&
                     !bus.flush && !st_hit && !snoop_hit;
        kill       = bus.flush || accept || st_hit || snoop_hit;
        // An ll coinciding with sc acceptance cannot occur in a single-issue pipe, so it is dropped.
        ll_take    = bus.ll_valid && !bus.flush && !accept;
        link_set   = ll_take && !kill && !ll_blocked;
    end

`ifdef LL_TIMEOUT_EN
    logic [15:0] age_q;

    assign timeout_hit = linked_q && (age_q == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            age_q <= '0;
        end else if (link_set) begin
            age_q <= '0;
        end else if (linked_q) begin
            age_q <= age_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every term reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            linked_q    <= 1'b0;
            link_addr_q <= '0;
            result_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state    <= S_RESP;
                    result_q <= sc_ok;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (ll_take) begin
                link_addr_q <= bus.ll_addr;
            end

            if (kill) begin
                linked_q <= 1'b0;
            end else if (ll_take) begin
                linked_q <= !ll_blocked;
            end else if (timeout_hit) begin
                linked_q <= 1'b0;
            end
        end
    end

    // NOTE: sc_pass stays combinational on flush so a flush during the response cycle still vetoes the store.
    assign bus.sc_ack    = (state == S_RESP);
    assign bus.sc_pass   = (state == S_RESP) && result_q && !bus.flush;
    assign bus.linked    = linked_q;
    assign bus.link_addr = link_addr_q;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.sc_addr[GRAN_LSB-1:0], bus.st_addr[GRAN_LSB-1:0],
                               bus.snoop_addr[GRAN_LSB-1:0]};
endmodule

// File: tb/tb_llsc_link_monitor.sv
// Self-checking bench for llsc_link_monitor: directed protocol scenarios, then randomized traffic vs a reference model.
module tb_llsc_link_monitor;
    localparam int AW = 32;
    localparam int GL = 2;
`ifdef LL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llsc_link_monitor_if #(.ADDR_W(AW)) bus ();

    llsc_link_monitor #(.ADDR_W(AW), .GRAN_LSB(GL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: link flag, LLAddr, pending response and its result, link age.
    bit          m_linked;
    bit          m_resp;
    bit          m_res;
    logic [AW-1:0] m_addr;
    int          m_age;
    bit          ack_prev;
    bit          req_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit granule_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> GL) == (b >> GL);
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] base;
        base = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
        return base;
    endfunction

    task automatic model_update();
        bit acc, st_h, sn_h, clear, take, blocked, expired;
        if (rst) begin
            m_linked = 0; m_addr = '0; m_resp = 0; m_res = 0; m_age = 0;
            return;
        end
        acc     = !m_resp && bus.sc_req;
        st_h    = bus.st_valid && granule_eq(bus.st_addr, m_addr);
        sn_h    = bus.snoop_valid && granule_eq(bus.snoop_addr, m_addr);
        clear   = bus.flush || acc || st_h || sn_h;
        take    = bus.ll_valid && !bus.flush && !acc;
        blocked = (bus.st_valid && granule_eq(bus.st_addr, bus.ll_addr)) ||
                  (bus.snoop_valid && granule_eq(bus.snoop_addr, bus.ll_addr));
`ifdef LL_TIMEOUT_EN
        expired = m_linked && (m_age == TO);
        if (bus.flush || (take && !clear && !blocked)) m_age = 0;
        else if (m_linked) m_age++;
`else
        expired = 0;
`endif
        if (acc) m_res = m_linked && granule_eq(bus.sc_addr, m_addr) && !bus.flush && !st_h && !sn_h;
        m_resp = acc;
        if (clear) m_linked = 0;
        else if (take) m_linked = !blocked;
        else if (expired) m_linked = 0;
        if (take) m_addr = bus.ll_addr;
    endtask

    // Inputs are set at the falling edge; outputs are compared 1 ns later, the model advances at the rising edge.
    task automatic step();
        ack_prev = m_resp;
        #1;
        check("sc_ack", bus.sc_ack, m_resp);
        check("sc_pass", bus.sc_pass, m_resp && m_res && !bus.flush);
        check("linked", bus.linked, m_linked);
        check("link_addr", bus.link_addr, m_addr);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.ll_valid = 0; bus.ll_addr = '0; bus.sc_req = 0; bus.sc_addr = '0;
        bus.st_valid = 0; bus.st_addr = '0; bus.snoop_valid = 0; bus.snoop_addr = '0;
    endtask

    task automatic do_ll(input logic [AW-1:0] a);
        bus.ll_valid = 1; bus.ll_addr = a;
        step();
        bus.ll_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_sc(input logic [AW-1:0] a, input bit flush_in_resp, output bit ack, output bit pass);
        bus.sc_req = 1; bus.sc_addr = a;
        step();
        bus.flush = flush_in_resp;
        #1;
        ack  = bus.sc_ack;
        pass = bus.sc_pass;
        step();
        bus.flush = 0;
        bus.sc_req = 0;
    endtask

    initial begin
        bit a, p;
        rst = 1;
        clear_inputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
        check("rst_linked", bus.linked, 0);
        check("rst_link_addr", bus.link_addr, 0);
        check("rst_sc_ack", bus.sc_ack, 0);
        rst = 0;
        step();

        do_ll(32'h1000); idle(3);
        do_sc(32'h1002, 0, a, p);
        check("basic_ack", a, 1);
        check("basic_pass", p, 1);
        #1 check("basic_unlinked", bus.linked, 0);

        do_ll(32'h1000);
        bus.snoop_valid = 1; bus.snoop_addr = 32'h1003; step(); bus.snoop_valid = 0;
        do_sc(32'h1000, 0, a, p);
        check("snoop_same_granule", p, 0);
        do_ll(32'h1000);
        bus.snoop_valid = 1; bus.snoop_addr = 32'h1004; step(); bus.snoop_valid = 0;
        do_sc(32'h1000, 0, a, p);
        check("snoop_next_granule", p, 1);

        do_ll(32'h2000);
        bus.flush = 1; step(); bus.flush = 0;
        do_sc(32'h2000, 0, a, p);
        check("flush_before_sc", p, 0);
        do_ll(32'h2000);
        do_sc(32'h2000, 1, a, p);
        check("flush_resp_ack", a, 1);
        check("flush_resp_pass", p, 0);

        do_ll(32'h3000);
        bus.snoop_valid = 1; bus.snoop_addr = 32'h3000;
        do_sc(32'h3000, 0, a, p);
        bus.snoop_valid = 0;
        check("snoop_at_accept", p, 0);
        do_ll(32'h3000);
        do_sc(32'h4000, 0, a, p);
        check("addr_mismatch", p, 0);

        do_ll(32'h5000);
        bus.sc_req = 1; bus.sc_addr = 32'h5000; rst = 1;
        step();
        rst = 0; bus.sc_req = 0;
        #1;
        check("rst_drop_ack", bus.sc_ack, 0);
        check("rst_drop_linked", bus.linked, 0);
        check("rst_drop_addr", bus.link_addr, 0);
        step();

`ifdef LL_TIMEOUT_EN
        do_ll(32'h6000); idle(9);
        #1 check("timeout_unlinked", bus.linked, 0);
        do_sc(32'h6000, 0, a, p);
        check("timeout_sc_fail", p, 0);
        do_ll(32'h6000); idle(4);
        do_sc(32'h6000, 0, a, p);
        check("timeout_early_sc", p, 1);
`endif

        req_on = 0;
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.flush       = ($urandom_range(0, 24) == 0);
            bus.ll_valid    = ($urandom_range(0, 5) == 0);
            bus.ll_addr     = rnd_addr();
            bus.st_valid    = ($urandom_range(0, 5) == 0);
            bus.st_addr     = rnd_addr();
            bus.snoop_valid = ($urandom_range(0, 5) == 0);
            bus.snoop_addr  = rnd_addr();
            if (rst || ack_prev) begin
                req_on = 0;
            end else if (!req_on && $urandom_range(0, 3) == 0) begin
                req_on = 1;
                bus.sc_addr = rnd_addr();
            end
            bus.sc_req = req_on;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
